// File: rtl/video_pkg.sv
// video_pkg: shared constants and types for the video output path.
//   VGA visible-area size, framebuffer word width, derived words per frame,
//   default colours and the fetch FSM state encoding.
package video_pkg;

  localparam int H_DISPLAY       = 640;
  localparam int V_DISPLAY       = 480;
  localparam int WORD_W          = 16;
  localparam int WORDS_PER_FRAME = H_DISPLAY * V_DISPLAY / WORD_W;
  localparam int WLEFT_W         = 16;

  localparam logic [2:0] COLOR_FG = 3'b111;
  localparam logic [2:0] COLOR_BG = 3'b000;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_REQ
  } fetch_state_e;

endpackage

// File: rtl/video_fetch_ctrl.sv
// video_fetch_ctrl: framebuffer fetch engine with a one-word prefetch buffer.
//   clk, reset     : pixel clock, synchronous active-high reset
//   frame_start    : restart address counter / word budget, flush buffer
//   load_shifter   : shifter is taking next_word this cycle (if valid)
//   mem_req/addr   : read request held until mem_ack
//   mem_ack/data   : one-cycle acknowledge with read data
//   next_word/valid: prefetch buffer handed to the shifter
module video_fetch_ctrl #(
  parameter int                WORD_W          = video_pkg::WORD_W,
  parameter int                ADDR_W          = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                WORDS_PER_FRAME = video_pkg::WORDS_PER_FRAME
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              load_shifter,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] next_word,
  output logic              next_valid
);
  import video_pkg::*;

  fetch_state_e        state;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [WLEFT_W-1:0]  words_left;
  logic                discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= BASE_ADDR;
      addr_cnt   <= BASE_ADDR;
      words_left <= '0;
      discard    <= 1'b0;
      next_word  <= '0;
      next_valid <= 1'b0;
    end else begin
      // Buffer drained by the shifter; the idle check below still sees the
      // pre-edge value, so the refill request starts one cycle later.
      if (load_shifter && next_valid)
        next_valid <= 1'b0;

      case (state)
        FETCH_IDLE: begin
          if (!next_valid && words_left != '0 && !frame_start) begin
            state    <= FETCH_REQ;
            mem_req  <= 1'b1;
            mem_addr <= addr_cnt;
          end
        end
        FETCH_REQ: begin
          if (mem_ack) begin
            state   <= FETCH_IDLE;
            mem_req <= 1'b0;
            if (discard) begin
              discard <= 1'b0;
            end else if (!frame_start) begin
              // An ack coinciding with frame_start belongs to the old frame.
              next_word  <= mem_data;
              next_valid <= 1'b1;
              addr_cnt   <= addr_cnt + ADDR_W'(1);
              if (words_left != '0)
                words_left <= words_left - WLEFT_W'(1);
            end
          end
        end
        default: state <= FETCH_IDLE;
      endcase

      if (frame_start) begin
        addr_cnt   <= BASE_ADDR;
        words_left <= WLEFT_W'(WORDS_PER_FRAME);
        next_valid <= 1'b0;
        // Request in flight cannot be aborted; drop its data when it lands.
        if (state == FETCH_REQ && !mem_ack)
          discard <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_shifter.sv
// video_shifter: serialises framebuffer words into MSB-first pixels.
//   clk, reset    : pixel clock, synchronous active-high reset
//   display_on    : visible-area flag, gates shifting and rgb
//   load_shifter  : moves prefetch word into the shifter
//   frame_start   : restarts the fetch address sequence
//   mem_*         : video RAM request/acknowledge read port
//   rgb           : registered pixel colour
//   underrun      : sticky, set when a load finds the buffer empty
module video_shifter #(
  parameter int                WORD_W          = video_pkg::WORD_W,
  parameter int                ADDR_W          = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                WORDS_PER_FRAME = video_pkg::WORDS_PER_FRAME,
  parameter logic [2:0]        FG_COLOR        = video_pkg::COLOR_FG,
  parameter logic [2:0]        BG_COLOR        = video_pkg::COLOR_BG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              display_on,
  input  logic              load_shifter,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic [2:0]        rgb,
  output logic              underrun
);
  import video_pkg::*;

  logic [WORD_W-1:0] next_word;
  logic              next_valid;
  logic [WORD_W-1:0] shift_reg;

  video_fetch_ctrl #(
    .WORD_W          (WORD_W),
    .ADDR_W          (ADDR_W),
    .BASE_ADDR       (BASE_ADDR),
    .WORDS_PER_FRAME (WORDS_PER_FRAME)
  ) u_fetch (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .load_shifter (load_shifter),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .next_word    (next_word),
    .next_valid   (next_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      underrun  <= 1'b0;
      rgb       <= 3'b000;
    end else begin
      if (load_shifter) begin
        if (next_valid) begin
          shift_reg <= next_word;
        end else begin
          shift_reg <= '0;
          underrun  <= 1'b1;
        end
      end else if (display_on) begin
        shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      end
      // rgb reflects the MSB as it stood before this edge's load/shift.
      rgb <= display_on ? (shift_reg[WORD_W-1] ? FG_COLOR : BG_COLOR) : 3'b000;
    end
  end

endmodule

// File: tb/tb_video_shifter.sv
module tb_video_shifter;

  localparam int WPF = 19200;

  logic        clk = 1'b0;
  logic        reset, display_on, load_shifter, frame_start, mem_ack;
  logic [15:0] mem_data;
  logic        mem_req, underrun;
  logic [14:0] mem_addr;
  logic [2:0]  rgb;

  video_shifter dut (
    .clk          (clk),
    .reset        (reset),
    .display_on   (display_on),
    .load_shifter (load_shifter),
    .frame_start  (frame_start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .rgb          (rgb),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: pixels as a queue of bits still to be shown, the
  // prefetch buffer as a word plus a flag, and the fetch side as
  // "outstanding request / drop its data / next address / words left".
  bit          pixq[$];
  bit          m_valid, m_req, m_drop, m_under;
  logic [15:0] m_word;
  logic [14:0] m_ctr, m_addr;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic do_reset();
    reset = 1'b1; display_on = 0; load_shifter = 0; frame_start = 0;
    mem_ack = 0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    pixq.delete();
    m_valid = 0; m_req = 0; m_drop = 0; m_under = 0;
    m_word = '0; m_ctr = '0; m_addr = '0; m_left = 0;
    chk("reset_rgb", 32'(rgb), 32'd0);
    check_all();
    reset = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on pre-edge values, compare.
  task automatic step(input bit ds, input bit ld, input bit fs, input bit ak,
                      input logic [15:0] dat);
    logic [2:0] exp_rgb;
    bit pv, preq;
    display_on = ds; load_shifter = ld; frame_start = fs;
    mem_ack = ak; mem_data = dat;

    exp_rgb = (ds && pixq.size() > 0 && pixq[0]) ? 3'b111 : 3'b000;
    pv   = m_valid;
    preq = m_req;

    if (ld) begin
      pixq.delete();
      if (pv) begin
        for (int k = 15; k >= 0; k--) pixq.push_back(m_word[k]);
        m_valid = 0;
      end else begin
        m_under = 1;
      end
    end else if (ds && pixq.size() > 0) begin
      void'(pixq.pop_front());
    end

    if (preq) begin
      if (ak) begin
        m_req = 0;
        if (m_drop) m_drop = 0;
        else if (!fs) begin
          m_valid = 1; m_word = dat; m_ctr = m_ctr + 15'd1;
          if (m_left > 0) m_left--;
        end
      end
    end else if (!pv && m_left != 0 && !fs) begin
      m_req = 1; m_addr = m_ctr;
    end

    if (fs) begin
      m_ctr = '0; m_left = WPF; m_valid = 0;
      if (preq && !ak) m_drop = 1;
    end

    @(posedge clk);
    #1;
    chk("rgb", 32'(rgb), 32'(exp_rgb));
    check_all();
  endtask

  initial begin
    logic [2:0] pat [16];
    logic [14:0] last_addr;
    int guard;
    pat = '{7,0,7,0,0,7,0,7,7,7,7,7,0,0,0,0};

    // Reset, then first request two edges after frame_start is sampled.
    do_reset();
    step(0, 0, 1, 0, '0);
    chk("no_req_in_fs", 32'(mem_req), 32'd0);
    step(0, 0, 0, 0, '0);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);

    // Pattern word A5F0 acked after 2 cycles, then loaded and shown.
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 16'hA5F0);
    step(1, 1, 0, 0, '0);
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 0, 0, '0);
      chk("pattern_rgb", 32'(rgb), 32'(pat[k]));
    end

    // Underrun: request for word 1 left outstanding, buffer empty.
    chk("req_word1", 32'(mem_addr), 32'd1);
    step(1, 1, 0, 0, '0);
    chk("underrun_set", 32'(underrun), 32'd1);
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 0, 0, '0);
      chk("underrun_bg", 32'(rgb), 32'd0);
    end

    // frame_start while request outstanding: ack 5 cycles later is dropped.
    step(0, 0, 1, 0, '0);
    repeat (4) step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 16'hDEAD);
    chk("drop_no_req", 32'(mem_req), 32'd0);
    step(0, 0, 0, 0, '0);
    chk("restart_req", 32'(mem_req), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Simultaneous ack and load with an empty buffer.
    step(1, 1, 0, 1, 16'h8001);
    chk("sim_underrun", 32'(underrun), 32'd1);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    chk("sim_first_px", 32'(rgb), 32'd7);
    for (int k = 1; k < 16; k++) step(1, 0, 0, 0, '0);
    chk("sim_last_px", 32'(rgb), 32'd7);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 7) != 0),
           bit'($urandom_range(0, 9) == 0),
           bit'($urandom_range(0, 299) == 0),
           m_req && ($urandom_range(0, 2) == 0),
           16'($urandom));
    end

    // Full frame: fetch until the word budget is spent.
    do_reset();
    step(0, 0, 1, 0, '0);
    guard = 0;
    last_addr = '0;
    while (!(m_left == 0 && !m_req) && guard < 70000) begin
      step(0, m_valid, 0, m_req, 16'($urandom));
      if (mem_req) last_addr = mem_addr;
      guard++;
    end
    chk("frame_bound", 32'(guard < 70000), 32'd1);
    chk("last_addr", 32'(last_addr), 32'(WPF - 1));
    for (int k = 0; k < 20; k++) step(0, bit'(k == 0 && m_valid), 0, 0, '0);
    chk("frame_done_idle", 32'(mem_req), 32'd0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("next_frame_req", 32'(mem_req), 32'd1);
    chk("next_frame_addr", 32'(mem_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_shifter.md
# video_shifter

Pixel-serialising stage directly downstream of the VGA sync generator. Fetches 16-bit monochrome framebuffer words from video RAM over a request/acknowledge port, holds one word in a prefetch buffer, and shifts pixels MSB-first onto a registered 3-bit RGB output. Consumes the sync generator's `load_shifter` and `display_on` strobes; `frame_start` is driven once per frame, on the first cycle of vsync.

## Interface
- `WORD_W`, 16: framebuffer word width, pixels per fetch.
- `ADDR_W`, 15: video RAM word-address width.
- `BASE_ADDR`, 0: word address of the first word of the frame.
- `WORDS_PER_FRAME`, 19200: words fetched per frame (640×480/16).
- `FG_COLOR`, 3'b111: RGB for a pixel bit of 1.
- `BG_COLOR`, 3'b000: RGB for a pixel bit of 0.

- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `display_on` in 1: visible-area flag from the sync generator.
- `load_shifter` in 1: one-cycle strobe that moves the prefetch word into the shifter.
- `frame_start` in 1: one-cycle strobe that restarts the address counter.
- `mem_req` out 1: read request; held high until acknowledged.
- `mem_addr` out `ADDR_W`: word address; stable while `mem_req` is high.
- `mem_ack` in 1: one-cycle acknowledge, with `mem_data` valid in the same cycle.
- `mem_data` in `WORD_W`: read data.
- `rgb` out 3: registered pixel colour.
- `underrun` out 1: sticky flag; set when a load finds the prefetch buffer empty.

## Operation
- **Fetch FSM**, two states: IDLE and REQ.
  - IDLE → REQ when all three hold: `next_valid`=0, `words_left`≠0, and `frame_start`=0. On the transition, `mem_addr` is driven from the address counter and `mem_req` goes to 1.
  - REQ → IDLE on `mem_ack`. The counter increments, `words_left` decrements, and `mem_data` is written into `next_word` with `next_valid`=1, unless the discard flag is set.
- **Prefetch buffer**: a single word `next_word` plus `next_valid`.
- **Load**, on `load_shifter`=1:
  - If `next_valid`=1: `shift_reg` ← `next_word`, and `next_valid` is cleared.
  - If `next_valid`=0: `shift_reg` ← 0 and `underrun` ← 1.
  - A load uses `next_valid` as it stood before the clock edge. If `mem_ack` and `load_shifter` occur in the same cycle while the buffer is empty, the result is an underrun, and the acked word lands in `next_word` for the next load.
- **Shift**: when `display_on`=1 and `load_shifter`=0, `shift_reg` shifts left one bit with zero fill. Otherwise it holds.
- **Pixel**: `rgb` ← `display_on` ? (`shift_reg[WORD_W-1]` ? `FG_COLOR` : `BG_COLOR`) : 3'b000.
- **`frame_start`**:
  - Address counter ← `BASE_ADDR`; `words_left` ← `WORDS_PER_FRAME`; `next_valid` ← 0.
  - If the FSM is in REQ, the request stays asserted until `mem_ack` (no abort), and a discard flag causes that word to be dropped.
  - No new request is issued in the `frame_start` cycle.
- **Address arithmetic**: `ADDR_W`-bit, wraps modulo 2^`ADDR_W`. `words_left` is 16 bits and saturates at 0, which stops fetching until the next `frame_start`.
- **Underrun**: `underrun` is cleared only by `reset`.

## Timing
- **Reset values**: `mem_req`=0, `mem_addr`=`BASE_ADDR`, `rgb`=0, `underrun`=0. Internally: `shift_reg`=0, `next_valid`=0, FSM=IDLE, `words_left`=0, discard=0.
- The first fetch after reset therefore waits for `frame_start`.
- **Request latency**: the first `mem_req` is high in the cycle after any cycle where the IDLE conditions hold.
- **Back-to-back fetch**: after an ack, the next request can start one cycle later, once the buffer has been emptied by a load.
- **Pixel latency**: `load_shifter` at edge N puts the word into `shift_reg` after N. Bit 15 appears on `rgb` after edge N+1, and bit 15−k after edge N+1+k (with `display_on` held at 1).
- **Memory timing**: `mem_ack` may arrive any number of cycles after `mem_req` rises, including the same cycle.
- **Reset during REQ**: `mem_req` drops on the next edge. The memory side must tolerate an abandoned request.

## Structure
- A shared package `video_pkg` holds:
  - the VGA timing constants (`H_DISPLAY` 640, `V_DISPLAY` 480),
  - `WORD_W`,
  - the derived `WORDS_PER_FRAME`,
  - the colour constants,
  - the fetch state enum (`FETCH_IDLE`, `FETCH_REQ`).
- One sub-module, `video_fetch_ctrl`, is natural. It contains the FSM, the address counter, `words_left`, the discard flag, and the prefetch buffer. The top level keeps the shifter and the `rgb` register.

## Test plan
- **Reset**: hold `reset` 3 cycles, then `frame_start` pulse → `mem_req`=1 with `mem_addr`=0 on the 2nd edge after the pulse; `rgb`=0 throughout.
- **Pattern**:
  - Stimulus: ack with `mem_data`=16'hA5F0 after 2 cycles, `load_shifter` pulse, `display_on`=1.
  - Required response: `rgb` sequence 7,0,7,0,0,7,0,7,7,7,7,7,0,0,0,0 starting 2 edges after the load.
- **Underrun**: `load_shifter` with `next_valid`=0 → 16 pixels of `BG_COLOR`, and `underrun`=1 and stays 1 through a later `frame_start`.
- **Simultaneous ack and load with empty buffer**: `underrun`=1, and the next load shifts out the acked word.
- **`frame_start` during REQ**: ack 5 cycles later → word discarded; next request has `mem_addr`=`BASE_ADDR`.
- **Full frame**: run 19200 fetches → no request after the 19200th ack until `frame_start`; `mem_addr` of the last request = 19199.
